or_rr_scheduler: RTL and testbench

Shares one REG_WIDTH-wide OR datapath instance among N_REQ requesters using round-robin arbitration and valid/ready handshakes. Each accepted request is computed as y = a | b and registered into a single-entry output slot. The result carries the winning requester's index and is held under downstream backpressure. The block sits between several operand producers and one result consumer, as the sequencing front end of the OR unit.

---
 rtl/or_rr_scheduler_pkg.sv | 18 +
 rtl/or_unit.sv | 12 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/or_rr_scheduler.sv | 89 ++++++++
 tb/tb_or_rr_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/or_rr_scheduler_pkg.sv
// Shared types, default widths and sizing helpers for the round-robin OR scheduler.
package or_sched_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   localparam int unsigned DEF_REG_WIDTH = 3;
   localparam int unsigned DEF_N_REQ     = 4;
   localparam int unsigned DEF_CNT_WIDTH = 8;

   // Index width that never collapses to zero bits, even for a single requester.
   function automatic int unsigned id_width(input int unsigned n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/or_unit.sv
// Bitwise OR datapath shared by the scheduler.
module or_unit #(
   parameter int unsigned REG_WIDTH = 3
) (
   input  logic [REG_WIDTH-1:0] a,
   input  logic [REG_WIDTH-1:0] b,
   output logic [REG_WIDTH-1:0] y
);

   assign y = a | b;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at ptr, pointer advances past the winner on accept.
module rr_arbiter
   import or_sched_pkg::*;
#(
   parameter int unsigned N    = DEF_N_REQ,
   parameter int unsigned ID_W = id_width(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            enable,
   input  logic            accept,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id
);

   logic [ID_W-1:0] ptr;
   logic [ID_W:0]   pos;
   logic            found;

   // One extra bit on pos keeps ptr+i from overflowing before the modulo fold.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      pos      = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pos = {1'b0, ptr} + (ID_W+1)'(i);
         if (pos >= (ID_W+1)'(N))
            pos = pos - (ID_W+1)'(N);
         if (enable && !found && req[pos[ID_W-1:0]]) begin
            found                 = 1'b1;
            grant[pos[ID_W-1:0]]  = 1'b1;
            grant_id              = pos[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (accept)
         ptr <= (grant_id == ID_W'(N-1)) ? '0 : grant_id + 1'b1;
   end

endmodule

// File: rtl/or_rr_scheduler.sv
// Shares one OR datapath among N_REQ requesters with round-robin arbitration and a single-entry result slot.
module or_rr_scheduler
   import or_sched_pkg::*;
#(
   parameter  int unsigned REG_WIDTH = DEF_REG_WIDTH,
   parameter  int unsigned N_REQ     = DEF_N_REQ,
   parameter  int unsigned CNT_WIDTH = DEF_CNT_WIDTH,
   localparam int unsigned ID_W      = id_width(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*REG_WIDTH-1:0] req_a,
   input  logic [N_REQ*REG_WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [REG_WIDTH-1:0]       rsp_y,
   output logic [ID_W-1:0]            rsp_id,
   output logic [CNT_WIDTH-1:0]       txn_cnt
);

   slot_state_t          state;
   logic                 can_accept;
   logic                 accept;
   logic [N_REQ-1:0]     grant;
   logic [ID_W-1:0]      grant_id;
   logic [REG_WIDTH-1:0] sel_a;
   logic [REG_WIDTH-1:0] sel_b;
   logic [REG_WIDTH-1:0] or_y;

   // rst gates the enable so no grant is offered while reset is held.
   assign can_accept = !rst && ((state == EMPTY) || rsp_ready);
   assign req_ready  = grant;
   assign accept     = |(req_valid & grant);
   assign rsp_valid  = (state == FULL);

   rr_arbiter #(
      .N    (N_REQ),
      .ID_W (ID_W)
   ) u_arb (
      .clk      (clk),
      .rst      (rst),
      .req      (req_valid),
      .enable   (can_accept),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_a = req_a[i*REG_WIDTH +: REG_WIDTH];
            sel_b = req_b[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

   or_unit #(
      .REG_WIDTH (REG_WIDTH)
   ) u_or (
      .a (sel_a),
      .b (sel_b),
      .y (or_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         rsp_y   <= '0;
         rsp_id  <= '0;
         txn_cnt <= '0;
      end else begin
         if (accept) begin
            rsp_y  <= or_y;
            rsp_id <= grant_id;
            state  <= FULL;
         end else if ((state == FULL) && rsp_ready) begin
            state <= EMPTY;
         end
         if ((state == FULL) && rsp_ready)
            txn_cnt <= txn_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_or_rr_scheduler.sv
// Randomized and directed bench for or_rr_scheduler with a scoreboard-driven result monitor.
module tb_or_rr_scheduler;

   localparam int unsigned W = 3;
   localparam int unsigned N = 4;
   localparam int unsigned C = 8;

   typedef struct packed {
      logic [W-1:0] y;
      logic [1:0]   id;
   } rsp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [W-1:0]   rsp_y;
   logic [1:0]     rsp_id;
   logic [C-1:0]   txn_cnt;

   int   checks = 0;
   int   failures = 0;
   rsp_t sb[$];

   // Reference model state: pending requests, rotating priority, slot occupancy, handshake count.
   bit           pend[N];
   logic [W-1:0] op_a[N];
   logic [W-1:0] op_b[N];
   int           m_ptr = 0;
   bit           m_full = 0;
   int           exp_cnt = 0;

   or_rr_scheduler #(
      .REG_WIDTH (W),
      .N_REQ     (N),
      .CNT_WIDTH (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_id    (rsp_id),
      .txn_cnt   (txn_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int winner();
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (pend[j]) return j;
      end
      return -1;
   endfunction

   task automatic ask(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!pend[i]) begin
         pend[i] = 1'b1;
         op_a[i] = a;
         op_b[i] = b;
      end
   endtask

   task automatic ask_rand(input int i);
      ask(i, W'($urandom), W'($urandom));
   endtask

   // Called at posedge+1; returns at the following posedge+1.
   task automatic step(input bit rdy);
      int         w;
      logic [N-1:0] exp_rdy;
      rsp_ready = rdy;
      for (int i = 0; i < N; i++) begin
         req_valid[i]     = pend[i];
         req_a[i*W +: W]  = op_a[i];
         req_b[i*W +: W]  = op_b[i];
      end
      #1;
      exp_rdy = '0;
      w = -1;
      if (!m_full || rdy) begin
         w = winner();
         if (w >= 0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, m_full);
      @(posedge clk);
      #1;
      if (w >= 0) begin
         rsp_t e;
         e.y  = op_a[w] | op_b[w];
         e.id = 2'(w);
         sb.push_back(e);
         m_ptr   = (w + 1) % N;
         m_full  = 1'b1;
         pend[w] = 1'b0;
      end else if (m_full && rdy) begin
         m_full = 1'b0;
      end
   endtask

   task automatic mid_reset();
      #1;
      rst = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_txn_cnt", txn_cnt, 0);
      chk("rst_req_ready", req_ready, 0);
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      req_valid = '0;
      sb.delete();
      m_full  = 1'b0;
      m_ptr   = 0;
      exp_cnt = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Monitor: compare every presented result with the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (!rst) begin
         chk("txn_cnt", txn_cnt, exp_cnt % (1 << C));
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               chk("rsp_y", rsp_y, sb[0].y);
               chk("rsp_id", rsp_id, sb[0].id);
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  exp_cnt++;
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0;
         op_a[i] = '0;
         op_b[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("init_rsp_valid", rsp_valid, 0);
      chk("init_rsp_y", rsp_y, 0);
      chk("init_txn_cnt", txn_cnt, 0);
      chk("init_req_ready", req_ready, 0);
      rst = 1'b0;

      // Single request from requester 2
      ask(2, 3'b001, 3'b100);
      step(1);
      step(1);
      step(1);

      // All requesters continuously valid
      for (int c = 0; c < 10; c++) begin
         for (int i = 0; i < N; i++) ask_rand(i);
         step(1);
      end
      step(1);

      // Backpressure with requesters 1 and 3 waiting
      ask(0, 3'b010, 3'b000);
      step(1);
      ask_rand(1);
      ask_rand(3);
      repeat (3) step(0);
      repeat (3) step(1);

      // Pointer wrap: grant to 3, then only 0 and 3 valid
      ask(3, 3'b011, 3'b000);
      step(1);
      ask_rand(0);
      ask_rand(3);
      repeat (3) step(1);

      // Mid-operation reset with a full slot
      ask(0, 3'b111, 3'b000);
      step(0);
      step(0);
      mid_reset();
      ask_rand(2);
      ask_rand(1);
      repeat (3) step(1);

      // Random traffic long enough to wrap txn_cnt
      for (int c = 0; c < 700; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(2) == 0) ask_rand(i);
         step($urandom_range(3) != 0);
      end
      repeat (8) step(1);
      chk("sb_drained", sb.size(), 0);
      chk("cnt_wrapped", exp_cnt > 256, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
